fetch_pc: RTL and testbench



---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_pc_branch_lut.sv | 19 +
 rtl/fetch_pc.sv | 139 +++++++++++++
 tb/tb_fetch_pc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Holds the FSM state encoding, default widths and the default branch-target table.
// Target table entry k holds absolute address 16*k.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam int PC_W_DEF   = 12;
    localparam int LUT_AW_DEF = 5;
    localparam int LUT_DEPTH  = 1 << LUT_AW_DEF;

    // Absolute jump/branch targets; entry k = 16*k.
    localparam logic [PC_W_DEF-1:0] DEFAULT_TGT [LUT_DEPTH] = '{
        12'd0,   12'd16,  12'd32,  12'd48,  12'd64,  12'd80,  12'd96,  12'd112,
        12'd128, 12'd144, 12'd160, 12'd176, 12'd192, 12'd208, 12'd224, 12'd240,
        12'd256, 12'd272, 12'd288, 12'd304, 12'd320, 12'd336, 12'd352, 12'd368,
        12'd384, 12'd400, 12'd416, 12'd432, 12'd448, 12'd464, 12'd480, 12'd496
    };

endpackage

// File: rtl/fetch_pc_branch_lut.sv
// Branch-target lookup: maps a register-supplied index to an absolute fetch address.
// Latency: combinational, zero cycles.
// Backpressure: none; pure ROM read.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic [LUT_AW-1:0] idx,
    output logic [PC_W-1:0]   tgt
);

    // Read the constant target table.
    always_comb begin
        tgt = PC_W'(DEFAULT_TGT[idx]);
    end

endmodule

// File: rtl/fetch_pc.sv
// Program-counter / fetch sequencer: IDLE/RUN/DONE FSM driving instr_ROM_ctr.
// Latency: a branch/jump decided in cycle N addresses its target in cycle N+1 (no delay slot).
// Backpressure: none; halt freezes the PC in DONE. Optional FETCH_PERF_CNT_EN adds run/taken counters.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int LUT_AW   = LUT_AW_DEF,
    parameter int PROG_LEN = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic              jumpEn,
    input  logic              condTaken,
    input  logic [LUT_AW-1:0] tgt_idx,
    output logic [PC_W-1:0]   instr_ROM_ctr,
    output logic              running,
    output logic              done
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       cycle_cnt,
    output logic [15:0]       taken_cnt
`endif
);

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic [PC_W-1:0]   lut_tgt;
    logic              taken;

    branch_lut #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) u_branch_lut (
        .idx (tgt_idx),
        .tgt (lut_tgt)
    );

    // Next-state and next-PC selection; halt beats branch beats end-of-program beats increment.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken   = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = DONE;
                end else if (jumpEn || condTaken) begin
                    pc_d  = lut_tgt;
                    taken = 1'b1;
                end else if (pc_q == LAST_PC) begin
                    state_d = DONE;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    // State, PC and registered status decodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign instr_ROM_ctr = pc_q;
    assign running       = running_q;
    assign done          = done_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
    logic [15:0] taken_cnt_q, taken_cnt_d;

    // Saturating counters; restart clears them, DONE/IDLE hold them.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (state_q != RUN && state_d == RUN) begin
            cycle_cnt_d = '0;
            taken_cnt_d = '0;
        end else if (state_q == RUN) begin
            if (cycle_cnt_q != 16'hFFFF) begin
                cycle_cnt_d = cycle_cnt_q + 16'd1;
            end
            if (taken && taken_cnt_q != 16'hFFFF) begin
                taken_cnt_d = taken_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            taken_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Table-driven bench for fetch_pc with PROG_LEN=8; counter checks when FETCH_PERF_CNT_EN is defined.
module tb_fetch_pc;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt;
    logic        jumpEn;
    logic        condTaken;
    logic [4:0]  tgt_idx;
    logic [11:0] instr_ROM_ctr;
    logic        running;
    logic        done;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cycle_cnt;
    logic [15:0] taken_cnt;
`endif

    int n_vec;
    int n_bad;

    fetch_pc #(
        .PC_W     (12),
        .LUT_AW   (5),
        .PROG_LEN (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .halt          (halt),
        .jumpEn        (jumpEn),
        .condTaken     (condTaken),
        .tgt_idx       (tgt_idx),
        .instr_ROM_ctr (instr_ROM_ctr),
        .running       (running),
        .done          (done)
`ifdef FETCH_PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .taken_cnt     (taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        st;
        logic        hl;
        logic        jp;
        logic        ct;
        logic [4:0]  idx;
        logic [11:0] pc;
        logic        run;
        logic        dn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic st, input logic hl, input logic jp,
                       input logic ct, input logic [4:0] idx, input logic [11:0] pc,
                       input logic run, input logic dn);
        vec_t v;
        v.rst = rst; v.st = st; v.hl = hl; v.jp = jp; v.ct = ct; v.idx = idx;
        v.pc = pc; v.run = run; v.dn = dn;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, and check the registered outputs.
    task automatic step(input string name, input logic rst, input logic st, input logic hl,
                        input logic jp, input logic ct, input logic [4:0] idx,
                        input logic [11:0] pc, input logic run, input logic dn);
        reset = rst; start = st; halt = hl; jumpEn = jp; condTaken = ct; tgt_idx = idx;
        @(posedge clk);
        #1;
        n_vec++;
        if (instr_ROM_ctr !== pc || running !== run || done !== dn) begin
            n_bad++;
            $display("FAIL %s: got pc=%0d running=%0b done=%0b, want pc=%0d running=%0b done=%0b",
                     name, instr_ROM_ctr, running, done, pc, run, dn);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic check_cnt(input string name, input logic [15:0] cyc, input logic [15:0] tk);
        n_vec++;
        if (cycle_cnt !== cyc || taken_cnt !== tk) begin
            n_bad++;
            $display("FAIL %s: got cycle_cnt=%0d taken_cnt=%0d, want cycle_cnt=%0d taken_cnt=%0d",
                     name, cycle_cnt, taken_cnt, cyc, tk);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1; start = 1'b0; halt = 1'b0; jumpEn = 1'b0; condTaken = 1'b0; tgt_idx = '0;

        //   rst st  hl  jp  ct  idx    pc     run dn
        add(1, 0, 0, 0, 0, 5'd0,  12'd0,   0, 0);  // reset state
        add(1, 1, 0, 0, 0, 5'd0,  12'd0,   0, 0);  // reset beats start
        add(0, 0, 0, 0, 0, 5'd0,  12'd0,   0, 0);  // idle holds
        add(0, 1, 0, 0, 0, 5'd0,  12'd0,   1, 0);  // start -> RUN at 0
        add(0, 0, 0, 0, 0, 5'd0,  12'd1,   1, 0);
        add(0, 1, 0, 0, 0, 5'd0,  12'd2,   1, 0);  // start ignored in RUN
        add(0, 0, 0, 0, 0, 5'd0,  12'd3,   1, 0);
        add(0, 0, 0, 0, 0, 5'd0,  12'd4,   1, 0);
        add(0, 0, 0, 0, 0, 5'd0,  12'd5,   1, 0);
        add(0, 0, 0, 1, 0, 5'd3,  12'd48,  1, 0);  // jump at 5 -> 48
        add(0, 0, 0, 0, 1, 5'd2,  12'd32,  1, 0);  // cond at 48 -> 32
        add(0, 0, 0, 1, 1, 5'd1,  12'd16,  1, 0);  // both high = one branch
        add(0, 0, 0, 0, 0, 5'd0,  12'd17,  1, 0);
        add(0, 0, 0, 1, 0, 5'd0,  12'd0,   1, 0);  // jump to 0
        for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, 0, 5'd0, 12'(k), 1, 0);
        add(0, 0, 0, 0, 0, 5'd0,  12'd7,   0, 1);  // end of program -> DONE
        add(0, 0, 0, 1, 0, 5'd3,  12'd7,   0, 1);  // DONE ignores jump
        add(0, 1, 0, 0, 0, 5'd0,  12'd0,   1, 0);  // restart from DONE
        for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, 0, 5'd0, 12'(k), 1, 0);
        add(0, 0, 0, 1, 0, 5'd1,  12'd16,  1, 0);  // branch on last addr, no DONE
        add(0, 0, 0, 0, 1, 5'd1,  12'd16,  1, 0);  // self-target stall
        add(0, 0, 1, 1, 0, 5'd3,  12'd16,  0, 1);  // halt beats jump
        add(0, 1, 0, 0, 0, 5'd0,  12'd0,   1, 0);
        add(0, 1, 0, 0, 0, 5'd0,  12'd1,   1, 0);  // start held, ignored
        add(0, 1, 1, 0, 0, 5'd0,  12'd1,   0, 1);  // halt with start held
        add(0, 1, 0, 0, 0, 5'd0,  12'd0,   1, 0);  // held start re-enters RUN
        add(0, 0, 0, 1, 0, 5'd31, 12'd496, 1, 0);  // top LUT entry
        add(0, 0, 0, 0, 0, 5'd0,  12'd497, 1, 0);  // beyond PROG_LEN keeps counting
        add(0, 0, 0, 1, 0, 5'd1,  12'd16,  1, 0);
        add(0, 0, 0, 0, 0, 5'd0,  12'd17,  1, 0);
        add(0, 0, 0, 0, 0, 5'd0,  12'd18,  1, 0);
        add(0, 0, 0, 0, 0, 5'd0,  12'd19,  1, 0);
        add(0, 0, 0, 0, 0, 5'd0,  12'd20,  1, 0);
        add(1, 1, 0, 1, 0, 5'd3,  12'd0,   0, 0);  // reset mid-run at 20
        add(0, 0, 0, 0, 0, 5'd0,  12'd0,   0, 0);
        add(0, 1, 0, 0, 0, 5'd0,  12'd0,   1, 0);
        add(0, 0, 1, 0, 0, 5'd0,  12'd0,   0, 1);
        add(1, 0, 0, 0, 0, 5'd0,  12'd0,   0, 0);  // reset clears done

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].st, vecs[i].hl, vecs[i].jp,
                 vecs[i].ct, vecs[i].idx, vecs[i].pc, vecs[i].run, vecs[i].dn);
        end

        // Start held high through a whole program: 0..7, DONE, then straight back to RUN.
        step("hold_start0", 0, 1, 0, 0, 0, 5'd0, 12'd0, 1, 0);
        for (int k = 1; k <= 7; k++)
            step($sformatf("hold_start%0d", k), 0, 1, 0, 0, 0, 5'd0, 12'(k), 1, 0);
        step("hold_start_done", 0, 1, 0, 0, 0, 5'd0, 12'd7, 0, 1);
        step("hold_start_rerun", 0, 1, 0, 0, 0, 5'd0, 12'd0, 1, 0);
        step("hold_start_reset", 1, 0, 0, 0, 0, 5'd0, 12'd0, 0, 0);

`ifdef FETCH_PERF_CNT_EN
        check_cnt("cnt_reset", 16'd0, 16'd0);
        step("perf_start", 0, 1, 0, 0, 0, 5'd0, 12'd0, 1, 0);
        step("perf_e1",  0, 0, 0, 0, 0, 5'd0, 12'd1, 1, 0);
        step("perf_e2",  0, 0, 0, 1, 0, 5'd0, 12'd0, 1, 0);
        step("perf_e3",  0, 0, 0, 0, 0, 5'd0, 12'd1, 1, 0);
        check_cnt("cnt_mid", 16'd3, 16'd1);
        step("perf_e4",  0, 0, 0, 1, 0, 5'd0, 12'd0, 1, 0);
        step("perf_e5",  0, 0, 0, 0, 0, 5'd0, 12'd1, 1, 0);
        step("perf_e6",  0, 0, 0, 0, 1, 5'd0, 12'd0, 1, 0);
        step("perf_e7",  0, 0, 0, 0, 0, 5'd0, 12'd1, 1, 0);
        step("perf_e8",  0, 0, 0, 0, 0, 5'd0, 12'd2, 1, 0);
        step("perf_e9",  0, 0, 0, 0, 0, 5'd0, 12'd3, 1, 0);
        step("perf_e10", 0, 0, 1, 1, 0, 5'd2, 12'd3, 0, 1);
        check_cnt("cnt_done", 16'd10, 16'd3);
        step("perf_hold", 0, 0, 0, 0, 0, 5'd0, 12'd3, 0, 1);
        check_cnt("cnt_hold", 16'd10, 16'd3);
        step("perf_restart", 0, 1, 0, 0, 0, 5'd0, 12'd0, 1, 0);
        check_cnt("cnt_restart", 16'd0, 16'd0);
        step("perf_run1", 0, 0, 0, 1, 0, 5'd1, 12'd16, 1, 0);
        check_cnt("cnt_run1", 16'd1, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
